sine_rom_arbiter: RTL and testbench

Shares one synchronous sine lookup ROM between up to N_REQ low-rate modulation sources: the auto-panner, tremolo, vibrato and spare LFO slots. Each requester presents a 12-bit phase address. The arbiter grants one requester per cycle in round-robin order, drives the single ROM port, and tracks each in-flight read by requester ID. Returned samples go into per-requester hold registers, which drive the modulation datapath between updates.

---
 rtl/sine_rom_arbiter.sv | 97 +++++++++
 tb/tb_sine_rom_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sine_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sine ROM between N_REQ requesters.
// Each returned sample lands in its requester's hold register with a one-cycle VALID pulse.
module sine_rom_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ*ADDR_W-1:0]   ADDR,
    output logic [N_REQ-1:0]          GNT,
    output logic                      ROM_CS,
    output logic [ADDR_W-1:0]         ROM_ADDR,
    input  logic [DATA_W-1:0]         ROM_DATA,
    output logic [N_REQ*DATA_W-1:0]   DATA_OUT,
    output logic [N_REQ-1:0]          VALID
);

    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic [ID_W-1:0] idx;

    // Stage 0 lines up with ROM_CS/ROM_ADDR; stage ROM_LAT lines up with ROM_DATA.
    logic [ROM_LAT:0] pipe_busy;
    logic [ID_W-1:0]  pipe_id [ROM_LAT+1];

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        GNT     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % N_REQ);
            if (!gnt_any && RESET && REQ[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        if (gnt_any) begin
            GNT[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ROM_CS   <= 1'b0;
            ROM_ADDR <= '0;
        end else begin
            ROM_CS <= gnt_any;
            if (gnt_any) begin
                ROM_ADDR <= ADDR[32'(gnt_id)*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pipe_busy <= '0;
            for (int unsigned k = 0; k <= ROM_LAT; k++) begin
                pipe_id[k] <= '0;
            end
        end else begin
            pipe_busy <= {pipe_busy[ROM_LAT-1:0], gnt_any};
            pipe_id[0] <= gnt_id;
            for (int unsigned k = 1; k <= ROM_LAT; k++) begin
                pipe_id[k] <= pipe_id[k-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DATA_OUT <= '0;
            VALID    <= '0;
        end else begin
            VALID <= '0;
            if (pipe_busy[ROM_LAT]) begin
                VALID[pipe_id[ROM_LAT]] <= 1'b1;
                DATA_OUT[32'(pipe_id[ROM_LAT])*DATA_W +: DATA_W] <= ROM_DATA;
            end
        end
    end

endmodule

// File: tb/tb_sine_rom_arbiter.sv
// Scoreboard bench for sine_rom_arbiter: reference model predicts grants, ROM
// issue and returned samples; a negedge monitor pops and compares.
module tb_sine_rom_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ROM_LAT = 1;

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic [N_REQ-1:0]        REQ;
    logic [N_REQ*ADDR_W-1:0] ADDR;
    logic [N_REQ-1:0]        GNT;
    logic                    ROM_CS;
    logic [ADDR_W-1:0]       ROM_ADDR;
    logic [DATA_W-1:0]       ROM_DATA;
    logic [N_REQ*DATA_W-1:0] DATA_OUT;
    logic [N_REQ-1:0]        VALID;

    sine_rom_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .ADDR(ADDR), .GNT(GNT),
        .ROM_CS(ROM_CS), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
        .DATA_OUT(DATA_OUT), .VALID(VALID)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM: sample = address + 0x1000, ROM_LAT cycles after the address.
    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge CLK) begin
        rom_pipe[0] <= 16'h1000 + 16'(ROM_ADDR);
        for (int k = 1; k < int'(ROM_LAT); k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign ROM_DATA = rom_pipe[ROM_LAT-1];

    typedef struct {
        int unsigned       due;
        int unsigned       id;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t                    sb[$];
    int unsigned             cyc = 0;
    int                      errors = 0;
    int                      checks = 0;
    int unsigned             mptr = 0;
    logic                    cur_cs = 1'b0, nxt_cs = 1'b0;
    logic [ADDR_W-1:0]       cur_addr = '0, nxt_addr = '0;
    logic [N_REQ*DATA_W-1:0] exp_hold = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: evaluated mid-cycle once stimulus has settled.
    initial begin
        forever begin
            logic [N_REQ-1:0]  exp_gnt;
            logic [ADDR_W-1:0] a;
            int unsigned       g;
            bit                found;
            @(posedge CLK);
            cyc++;
            #2;
            exp_gnt = '0;
            if (!RESET) begin
                sb.delete();
                exp_hold = '0;
                mptr = 0;
                cur_cs = 1'b0; cur_addr = '0;
                nxt_cs = 1'b0; nxt_addr = '0;
            end else begin
                cur_cs   = nxt_cs;
                cur_addr = nxt_addr;
                nxt_cs   = 1'b0;
                found    = 1'b0;
                g        = 0;
                for (int unsigned k = 0; k < N_REQ; k++) begin
                    if (!found && REQ[(mptr + k) % N_REQ]) begin
                        found = 1'b1;
                        g = (mptr + k) % N_REQ;
                    end
                end
                if (found) begin
                    a = ADDR[g*ADDR_W +: ADDR_W];
                    exp_gnt[g] = 1'b1;
                    sb.push_back('{due: cyc + 2 + ROM_LAT, id: g, data: 16'h1000 + 16'(a)});
                    nxt_cs   = 1'b1;
                    nxt_addr = a;
                    mptr     = (g + 1) % N_REQ;
                end
            end
            check("GNT", 64'(GNT), 64'(exp_gnt));
        end
    end

    // Monitor: compares registered outputs on the falling edge.
    initial begin
        forever begin
            logic [N_REQ-1:0] exp_valid;
            exp_t e;
            @(negedge CLK);
            exp_valid = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                exp_valid[e.id] = 1'b1;
                exp_hold[e.id*DATA_W +: DATA_W] = e.data;
            end
            check("VALID", 64'(VALID), 64'(exp_valid));
            check("DATA_OUT", 64'(DATA_OUT), 64'(exp_hold));
            check("ROM_CS", 64'(ROM_CS), 64'(cur_cs));
            check("ROM_ADDR", 64'(ROM_ADDR), 64'(cur_addr));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_addr(input int unsigned i, input logic [ADDR_W-1:0] a);
        ADDR[i*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        RESET = 1'b0;
        REQ   = '1;
        ADDR  = '0;
        repeat (3) tick();

        // All requesters continuously: rotation 0,1,2,3,...
        for (int unsigned i = 0; i < N_REQ; i++) set_addr(i, ADDR_W'(12'h100 * (i + 1)));
        RESET = 1'b1;
        repeat (8) tick();
        REQ = '0;
        repeat (5) tick();

        // Single read from requester 2
        set_addr(2, 12'h080);
        REQ = 4'b0100;
        tick();
        REQ = '0;
        repeat (5) tick();

        // Pointer skip and wrap: grant 0, then 3, then 0
        REQ = 4'b0001;
        tick();
        REQ = 4'b1001;
        tick();
        tick();
        REQ = '0;
        repeat (5) tick();

        // Back-to-back reads from requester 1
        REQ = 4'b0010;
        for (int unsigned a = 0; a < 4; a++) begin
            set_addr(1, ADDR_W'(a));
            tick();
        end
        REQ = '0;
        repeat (5) tick();

        // Reset one cycle after a grant discards the in-flight read
        set_addr(0, 12'h3ff);
        REQ = 4'b0001;
        tick();
        REQ = '0;
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        repeat (5) tick();

        // Randomized traffic with occasional resets
        repeat (400) begin
            RESET = ($urandom_range(0, 59) != 0);
            REQ   = N_REQ'($urandom);
            for (int unsigned i = 0; i < N_REQ; i++) set_addr(i, ADDR_W'($urandom_range(0, 4095)));
            tick();
        end
        RESET = 1'b1;
        REQ   = '0;
        repeat (8) tick();

        check("SB_EMPTY", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
